jt49_busarb: RTL and testbench

JT49_BUSARB -- requirements
Module: jt49_busarb

---
 rtl/jt49_busarb_pkg.sv | 22 ++
 rtl/jt49_busarb.sv | 123 ++++++++++++
 tb/tb_jt49_busarb.sv | 297 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/jt49_busarb_pkg.sv
// Shared jt49 definitions: arbiter FSM state encodings, PSG register addresses
// and the two-port winner selection used by the bus arbiter.
package jt49_busarb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_GAP    = 2'd2
  } state_t;

  localparam logic [3:0] REG_A_FINE    = 4'h0;
  localparam logic [3:0] REG_ENV_SHAPE = 4'hD;

  // On a collision round-robin hands the bus to the port not granted last;
  // fixed priority always picks port 0. A lone requester always wins.
  function automatic logic pick_winner(input logic e0, input logic e1,
                                       input logic last, input bit rr);
    if (e0 && e1) return rr ? ~last : 1'b0;
    return e1;
  endfunction

endpackage

// File: rtl/jt49_busarb.sv
// Two-port arbiter in front of a jt49 PSG: grants one access at a time, strobes
// the PSG bus for WRLEN enabled cycles, then a GAP cycle that captures read data.
module jt49_busarb
  import jt49_busarb_pkg::*;
#(
  parameter int WRLEN = 2,
  parameter bit RR    = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clk_en,
  input  logic       req0,
  input  logic       req1,
  input  logic       we0,
  input  logic       we1,
  input  logic [3:0] addr0,
  input  logic [3:0] addr1,
  input  logic [7:0] din0,
  input  logic [7:0] din1,
  output logic       ack0,
  output logic       ack1,
  output logic [7:0] rdata0,
  output logic [7:0] rdata1,
  output logic [3:0] psg_addr,
  output logic [7:0] psg_din,
  output logic       psg_cs_n,
  output logic       psg_wr_n,
  input  logic [7:0] psg_dout
);

  state_t     state, state_nx;
  logic [3:0] cnt, cnt_nx;
  logic       gnt, gnt_nx;
  logic       last, last_nx;
  logic       we_l, we_nx;
  logic [3:0] addr_nx;
  logic [7:0] din_nx;
  logic       cs_n_nx, wr_n_nx;
  logic       ack0_nx, ack1_nx;
  logic       elig0, elig1, win;

  // A request is invisible during its own ack cycle, so a master that still
  // holds req while seeing ack is not granted a second time.
  assign elig0 = req0 & ~ack0;
  assign elig1 = req1 & ~ack1;
  assign win   = pick_winner(elig0, elig1, last, RR);

  always_comb begin
    // NOTE: every signal gets a default before the case so no latch is inferred.
    state_nx = state;
    cnt_nx   = cnt;
    gnt_nx   = gnt;
    last_nx  = last;
    we_nx    = we_l;
    addr_nx  = psg_addr;
    din_nx   = psg_din;
    ack0_nx  = 1'b0;
    ack1_nx  = 1'b0;
    if (clk_en) begin
      unique case (state)
        ST_IDLE: begin
          if (elig0 || elig1) begin
            state_nx = ST_ACCESS;
            cnt_nx   = 4'(WRLEN - 1);
            gnt_nx   = win;
            last_nx  = win;
            we_nx    = win ? we1   : we0;
            addr_nx  = win ? addr1 : addr0;
            din_nx   = win ? din1  : din0;
          end
        end
        ST_ACCESS: begin
          if (cnt == 4'd0) state_nx = ST_GAP;
          else             cnt_nx   = cnt - 4'd1;
        end
        ST_GAP: begin
          state_nx = ST_IDLE;
          ack0_nx  = ~gnt;
          ack1_nx  = gnt;
        end
        default: state_nx = ST_IDLE;
      endcase
    end
    // Bus strobes are derived from the next state so they leave a flop directly.
    cs_n_nx = (state_nx != ST_ACCESS);
    wr_n_nx = !((state_nx == ST_ACCESS) && we_nx);
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      cnt      <= 4'd0;
      gnt      <= 1'b0;
      last     <= 1'b1;
      we_l     <= 1'b0;
      psg_addr <= 4'd0;
      psg_din  <= 8'd0;
      psg_cs_n <= 1'b1;
      psg_wr_n <= 1'b1;
      ack0     <= 1'b0;
      ack1     <= 1'b0;
      rdata0   <= 8'd0;
      rdata1   <= 8'd0;
    end else begin
      state    <= state_nx;
      cnt      <= cnt_nx;
      gnt      <= gnt_nx;
      last     <= last_nx;
      we_l     <= we_nx;
      psg_addr <= addr_nx;
      psg_din  <= din_nx;
      psg_cs_n <= cs_n_nx;
      psg_wr_n <= wr_n_nx;
      ack0     <= ack0_nx;
      ack1     <= ack1_nx;
      if (ack0_nx && !we_l) rdata0 <= psg_dout;
      if (ack1_nx && !we_l) rdata1 <= psg_dout;
    end
  end

endmodule

// File: tb/tb_jt49_busarb.sv
// Bench for jt49_busarb: a fixed-priority and a round-robin instance, each with
// its own PSG register model, checked every cycle against a transaction model.
module tb_jt49_busarb;
  import jt49_busarb_pkg::*;

  localparam int WRLEN = 2;
  localparam int NL    = 2;   // lane 0: RR=0, lane 1: RR=1

  logic clk = 1'b0;
  logic rst_n, clk_en;
  always #5 clk = ~clk;

  logic       req0 [NL], req1 [NL], we0 [NL], we1 [NL];
  logic [3:0] addr0 [NL], addr1 [NL];
  logic [7:0] din0 [NL], din1 [NL];
  logic       ack0 [NL], ack1 [NL], cs_n [NL], wr_n [NL];
  logic [3:0] paddr [NL];
  logic [7:0] pdin [NL], rd0 [NL], rd1 [NL];
  logic [7:0] pdout [NL] = '{default: 8'h00};

  jt49_busarb #(.WRLEN(WRLEN), .RR(1'b0)) u_fp (
    .clk(clk), .rst_n(rst_n), .clk_en(clk_en),
    .req0(req0[0]), .req1(req1[0]), .we0(we0[0]), .we1(we1[0]),
    .addr0(addr0[0]), .addr1(addr1[0]), .din0(din0[0]), .din1(din1[0]),
    .ack0(ack0[0]), .ack1(ack1[0]), .rdata0(rd0[0]), .rdata1(rd1[0]),
    .psg_addr(paddr[0]), .psg_din(pdin[0]), .psg_cs_n(cs_n[0]),
    .psg_wr_n(wr_n[0]), .psg_dout(pdout[0])
  );

  jt49_busarb #(.WRLEN(WRLEN), .RR(1'b1)) u_rr (
    .clk(clk), .rst_n(rst_n), .clk_en(clk_en),
    .req0(req0[1]), .req1(req1[1]), .we0(we0[1]), .we1(we1[1]),
    .addr0(addr0[1]), .addr1(addr1[1]), .din0(din0[1]), .din1(din1[1]),
    .ack0(ack0[1]), .ack1(ack1[1]), .rdata0(rd0[1]), .rdata1(rd1[1]),
    .psg_addr(paddr[1]), .psg_din(pdin[1]), .psg_cs_n(cs_n[1]),
    .psg_wr_n(wr_n[1]), .psg_dout(pdout[1])
  );

  // PSG register file with one-clk registered read port; counts fresh write
  // edges to the envelope shape register (each one restarts the envelope).
  logic [7:0] regs [NL][16] = '{default: '{default: 8'h00}};
  bit         env_q [NL]    = '{default: 1'b0};
  int         env_cnt [NL]  = '{default: 0};

  always @(posedge clk) begin
    for (int l = 0; l < NL; l++) begin
      if (!cs_n[l] && !wr_n[l]) regs[l][paddr[l]] <= pdin[l];
      pdout[l] <= regs[l][paddr[l]];
      env_q[l] <= !cs_n[l] && !wr_n[l] && (paddr[l] == REG_ENV_SHAPE);
      if (!cs_n[l] && !wr_n[l] && (paddr[l] == REG_ENV_SHAPE) && !env_q[l])
        env_cnt[l] <= env_cnt[l] + 1;
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input int l, input logic [7:0] act,
                       input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s lane%0d @%0t: got %0h, expected %0h", name, l, $time, act, exp);
    end
  endtask

  // Transaction model: an access is described by its port and how many enabled
  // edges have passed since the grant; the strobe spans ticks 1..WRLEN, tick
  // WRLEN+1 is the gap, and the edge ending the gap completes the access.
  bit         m_busy [NL], m_port [NL], m_last [NL], m_we [NL];
  int         m_k [NL];
  logic [3:0] m_addr [NL];
  logic [7:0] m_din [NL];
  bit         m_ack [NL][2];
  logic [7:0] m_rd [NL][2];
  logic [7:0] dout_snap [NL];

  task automatic model_reset();
    for (int l = 0; l < NL; l++) begin
      m_busy[l] = 0; m_port[l] = 0; m_last[l] = 1; m_we[l] = 0; m_k[l] = 0;
      m_addr[l] = 4'h0; m_din[l] = 8'h00;
      m_ack[l][0] = 0; m_ack[l][1] = 0; m_rd[l][0] = 8'h00; m_rd[l][1] = 8'h00;
    end
  endtask

  task automatic model_tick(input int l);
    bit e0, e1, p, n0, n1;
    n0 = 0; n1 = 0;
    if (clk_en) begin
      if (m_busy[l]) begin
        if (m_k[l] == WRLEN + 1) begin
          if (m_port[l]) n1 = 1; else n0 = 1;
          if (!m_we[l]) m_rd[l][m_port[l]] = dout_snap[l];
          m_busy[l] = 0;
        end else m_k[l]++;
      end else begin
        e0 = req0[l] && !m_ack[l][0];
        e1 = req1[l] && !m_ack[l][1];
        if (e0 || e1) begin
          if (e0 && e1) p = (l == 1) ? !m_last[l] : 1'b0;
          else          p = e1;
          m_busy[l] = 1; m_k[l] = 1; m_port[l] = p; m_last[l] = p;
          m_we[l]   = p ? we1[l]   : we0[l];
          m_addr[l] = p ? addr1[l] : addr0[l];
          m_din[l]  = p ? din1[l]  : din0[l];
        end
      end
    end
    m_ack[l][0] = n0;
    m_ack[l][1] = n1;
  endtask

  task automatic compare_all();
    bit strobe;
    for (int l = 0; l < NL; l++) begin
      strobe = m_busy[l] && (m_k[l] <= WRLEN);
      check("psg_cs_n", l, cs_n[l], !strobe);
      check("psg_wr_n", l, wr_n[l], !(strobe && m_we[l]));
      check("psg_addr", l, paddr[l], m_addr[l]);
      check("psg_din",  l, pdin[l], m_din[l]);
      check("ack0",     l, ack0[l], m_ack[l][0]);
      check("ack1",     l, ack1[l], m_ack[l][1]);
      check("rdata0",   l, rd0[l], m_rd[l][0]);
      check("rdata1",   l, rd1[l], m_rd[l][1]);
    end
  endtask

  // Masters hold req through the ack cycle and drop it on the next edge,
  // unless hold keeps the same request standing as a new one.
  bit rand_mode = 0;
  bit hold [NL] = '{default: 1'b0};
  bit seen0 [NL] = '{default: 1'b0};
  bit seen1 [NL] = '{default: 1'b0};

  task automatic issue(input int l, input int p, input bit we, input logic [3:0] a,
                       input logic [7:0] d);
    if (p == 0) begin req0[l] = 1; we0[l] = we; addr0[l] = a; din0[l] = d; end
    else        begin req1[l] = 1; we1[l] = we; addr1[l] = a; din1[l] = d; end
  endtask

  task automatic masters();
    for (int l = 0; l < NL; l++) begin
      if (seen0[l]) begin seen0[l] = 0; if (!hold[l]) req0[l] = 0; end
      if (seen1[l]) begin seen1[l] = 0; if (!hold[l]) req1[l] = 0; end
      if (rand_mode && !req0[l] && $urandom_range(0, 2) == 0)
        issue(l, 0, 1'($urandom), 4'($urandom), 8'($urandom));
      if (rand_mode && !req1[l] && $urandom_range(0, 2) == 0)
        issue(l, 1, 1'($urandom), 4'($urandom), 8'($urandom));
      if (ack0[l]) seen0[l] = 1;
      if (ack1[l]) seen1[l] = 1;
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
    for (int l = 0; l < NL; l++) begin
      if (!rst_n) model_reset();
      else        model_tick(l);
    end
    masters();
    @(negedge clk);
    compare_all();
    for (int l = 0; l < NL; l++) dout_snap[l] = pdout[l];
  endtask

  task automatic wait_ack(input int l, input int p, input int bound, input bit chk_wr);
    bit got;
    got = 0;
    for (int n = 0; n < bound && !got; n++) begin
      cycle();
      if (chk_wr) check("read_keeps_wr_n_high", l, wr_n[l], 1'b1);
      got = (p == 0) ? ack0[l] : ack1[l];
    end
    check("ack_arrives", l, got, 1'b1);
  endtask

  initial begin
    int   t0, t1, e_before;
    logic cs_rec [6], wr_rec [6], ak_rec [6];
    int   seq [$];

    rst_n = 0; clk_en = 0;
    for (int l = 0; l < NL; l++) begin
      req0[l] = 0; req1[l] = 0; we0[l] = 0; we1[l] = 0;
      addr0[l] = 0; addr1[l] = 0; din0[l] = 0; din1[l] = 0;
      dout_snap[l] = 8'h00;
    end
    model_reset();
    repeat (3) cycle();
    check("reset_cs_n", 0, cs_n[0], 1'b1);
    check("reset_wr_n", 1, wr_n[1], 1'b1);
    check("reset_addr", 0, paddr[0], 4'h0);
    check("reset_ack0", 0, ack0[0], 1'b0);
    check("reset_rdata0", 1, rd0[1], 8'h00);
    rst_n = 1; clk_en = 1;
    repeat (2) cycle();

    // Single write: strobe in cycles 1-2, ack in cycle 4 only.
    issue(0, 0, 1'b1, 4'h8, 8'h0F);
    for (int c = 1; c <= 5; c++) begin
      cycle();
      cs_rec[c] = cs_n[0]; wr_rec[c] = wr_n[0]; ak_rec[c] = ack0[0];
      if (c == 1) begin
        check("wr_addr", 0, paddr[0], 4'h8);
        check("wr_din", 0, pdin[0], 8'h0F);
      end
    end
    check("wr_cs_c1", 0, cs_rec[1], 1'b0);
    check("wr_cs_c2", 0, cs_rec[2], 1'b0);
    check("wr_wr_c2", 0, wr_rec[2], 1'b0);
    check("wr_cs_c3", 0, cs_rec[3], 1'b1);
    check("wr_ack_c3", 0, ak_rec[3], 1'b0);
    check("wr_ack_c4", 0, ak_rec[4], 1'b1);
    check("wr_ack_c5", 0, ak_rec[5], 1'b0);
    repeat (2) cycle();

    // Write then read back register 0.
    issue(0, 0, 1'b1, REG_A_FINE, 8'h5A);
    wait_ack(0, 0, 10, 1'b0);
    repeat (2) cycle();
    issue(0, 0, 1'b0, REG_A_FINE, 8'hFF);
    wait_ack(0, 0, 10, 1'b1);
    check("read_rdata0", 0, rd0[0], 8'h5A);
    repeat (2) cycle();

    // Fixed-priority collision: port 0 acked in cycle 4, port 1 in cycle 8.
    issue(0, 0, 1'b1, 4'h3, 8'h11);
    issue(0, 1, 1'b1, 4'h4, 8'h22);
    t0 = 0; t1 = 0;
    for (int c = 1; c <= 10; c++) begin
      cycle();
      if (ack0[0] && t0 == 0) t0 = c;
      if (ack1[0] && t1 == 0) t1 = c;
    end
    check("fp_ack0_cycle", 0, 8'(t0), 8'd4);
    check("fp_ack1_cycle", 0, 8'(t1), 8'd8);

    // Round-robin with both ports requesting continuously.
    hold[1] = 1;
    issue(1, 0, 1'b1, 4'h5, 8'h33);
    issue(1, 1, 1'b1, 4'h6, 8'h44);
    for (int c = 1; c <= 16; c++) begin
      cycle();
      if (ack0[1]) seq.push_back(0);
      if (ack1[1]) seq.push_back(1);
    end
    hold[1] = 0;
    check("rr_ack_count", 1, 8'(seq.size()), 8'd4);
    for (int i = 0; i < seq.size() && i < 4; i++)
      check("rr_order", 1, 8'(seq[i]), 8'(i % 2));
    repeat (12) cycle();

    // Back-to-back envelope-shape writes each restart the envelope.
    e_before = env_cnt[0];
    hold[0] = 1;
    issue(0, 0, 1'b1, REG_ENV_SHAPE, 8'h0E);
    wait_ack(0, 0, 10, 1'b0);
    cycle();
    hold[0] = 0;
    wait_ack(0, 0, 10, 1'b0);
    repeat (3) cycle();
    check("env_restarts", 0, 8'(env_cnt[0] - e_before), 8'd2);

    // Reset in the middle of a strobe aborts it; the held request is redone.
    issue(0, 0, 1'b1, 4'h9, 8'h77);
    repeat (2) cycle();
    check("pre_reset_cs_n", 0, cs_n[0], 1'b0);
    rst_n = 0;
    #1;
    check("async_reset_cs_n", 0, cs_n[0], 1'b1);
    check("async_reset_wr_n", 0, wr_n[0], 1'b1);
    model_reset();
    repeat (2) cycle();
    check("reset_no_ack", 0, ack0[0], 1'b0);
    rst_n = 1;
    wait_ack(0, 0, 12, 1'b0);
    check("retry_wrote", 0, regs[0][9], 8'h77);
    repeat (2) cycle();

    // Randomized traffic with clk_en stalls and one mid-run reset.
    rand_mode = 1;
    for (int i = 0; i < 3000; i++) begin
      clk_en = ($urandom_range(0, 3) != 0);
      rst_n  = !(i >= 1500 && i < 1502);
      cycle();
    end
    rand_mode = 0;
    clk_en = 1;
    rst_n = 1;
    repeat (30) cycle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
